// File: rtl/conv3x3_window.sv
// -----------------------------------------------------------------------------
// conv3x3_window
//
// Streaming 3x3 window generator for the convolution datapath. Pixels arrive
// one per cycle in raster order over a valid/ready handshake. Two line buffers
// hold the previous two image rows and a 3x3 register array slides one column
// per accepted pixel. Every complete neighbourhood (no padding) is presented
// as nine parallel words, row-major, on win0..win8, giving
// (IMG_W-2)*(IMG_H-2) windows per frame.
//
// Optional feature macro: CONV3X3_WIN_COORD_EN
//   When defined, win_row/win_col report the top-left coordinate of the
//   window currently on win0..win8.
//
// Parameters:
//   bit_depth  pixel word width
//   IMG_W      image width in pixels  (>= 3)
//   IMG_H      image height in pixels (>= 3)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pix_in     input pixel, raster order
//   pix_valid  pix_in valid
//   pix_sof    accepted pixel is frame position (0,0)
//   pix_ready  block can accept a pixel this cycle
//   win0..win8 window words, win0 = top-left, win8 = bottom-right
//   win_valid  window outputs valid
//   win_last   final window of a frame
//   win_ready  downstream accepts the window
//   win_row    (macro only) top-left row of the window
//   win_col    (macro only) top-left column of the window
// -----------------------------------------------------------------------------
module conv3x3_window #(
    parameter int bit_depth = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [bit_depth-1:0]       pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic                       pix_ready,
    output logic [bit_depth-1:0]       win0,
    output logic [bit_depth-1:0]       win1,
    output logic [bit_depth-1:0]       win2,
    output logic [bit_depth-1:0]       win3,
    output logic [bit_depth-1:0]       win4,
    output logic [bit_depth-1:0]       win5,
    output logic [bit_depth-1:0]       win6,
    output logic [bit_depth-1:0]       win7,
    output logic [bit_depth-1:0]       win8,
    output logic                       win_valid,
    output logic                       win_last,
`ifdef CONV3X3_WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
`endif
    input  logic                       win_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // Raster position of the next pixel to be accepted
    logic [CW-1:0]        col_r;
    logic [RW-1:0]        row_r;

    // Position the current pixel actually occupies (sof overrides counters)
    logic [CW-1:0]        pos_col_s;
    logic [RW-1:0]        pos_row_s;
    logic [CW-1:0]        next_col_s;
    logic [RW-1:0]        next_row_s;

    logic                 accept_s;
    logic                 win_accept_s;
    logic                 load_s;
    logic                 last_s;

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column
    logic [bit_depth-1:0] lb1_r [IMG_W];
    logic [bit_depth-1:0] lb2_r [IMG_W];
    logic [bit_depth-1:0] tap1_s;
    logic [bit_depth-1:0] tap2_s;

    // Sliding 3x3 array, [row][col]; column 2 is the most recent column
    logic [bit_depth-1:0] arr_r [3][3];

    // Window output register, row-major
    logic [bit_depth-1:0] win_r [9];
    logic                 win_valid_r;
    logic                 win_last_r;

`ifdef CONV3X3_WIN_COORD_EN
    logic [RW-1:0]        win_row_r;
    logic [CW-1:0]        win_col_r;
`endif

    // Handshake: a single output register, so space exists whenever it is
    // empty or being drained this cycle
    assign pix_ready    = ~win_valid_r | win_ready;
    assign accept_s     = pix_valid & pix_ready;
    assign win_accept_s = win_valid_r & win_ready;

    // Column taps of the two buffered rows at the current column
    assign tap1_s = lb1_r[pos_col_s];
    assign tap2_s = lb2_r[pos_col_s];

    // Effective position of the presented pixel and the position after it
    always_comb begin
        pos_col_s  = col_r;
        pos_row_s  = row_r;
        next_col_s = col_r;
        next_row_s = row_r;
        if (pix_sof) begin
            pos_col_s = {CW{1'b0}};
            pos_row_s = {RW{1'b0}};
        end else begin
            pos_col_s = col_r;
            pos_row_s = row_r;
        end
        if (pos_col_s == CW'(IMG_W - 1)) begin
            next_col_s = {CW{1'b0}};
            if (pos_row_s == RW'(IMG_H - 1)) begin
                next_row_s = {RW{1'b0}};
            end else begin
                next_row_s = pos_row_s + RW'(1);
            end
        end else begin
            next_col_s = pos_col_s + CW'(1);
            next_row_s = pos_row_s;
        end
    end

    // A full neighbourhood exists once two rows and two columns precede it
    assign load_s = accept_s && (pos_row_s >= RW'(2)) && (pos_col_s >= CW'(2));
    assign last_s = (pos_row_s == RW'(IMG_H - 1)) && (pos_col_s == CW'(IMG_W - 1));

    // Raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (accept_s) begin
            col_r <= next_col_s;
            row_r <= next_row_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Line buffers: the older row ripples down, the new pixel enters row r-1.
    // Left unreset: stale words are never used thanks to the row/col gating.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_r[pos_col_s] <= tap1_s;
            lb1_r[pos_col_s] <= pix_in;
        end
    end

    // Sliding 3x3 array: shift one column left, new column from taps + pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    arr_r[r][c] <= {bit_depth{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                arr_r[r][0] <= arr_r[r][1];
                arr_r[r][1] <= arr_r[r][2];
            end
            arr_r[0][2] <= tap2_s;
            arr_r[1][2] <= tap1_s;
            arr_r[2][2] <= pix_in;
        end
    end

    // Window output register: loading a new window wins over draining the
    // old one, so back-to-back windows keep win_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= {bit_depth{1'b0}};
            end
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else if (load_s) begin
            // Columns c-2, c-1 come from the array, column c from taps/pixel
            win_r[0]    <= arr_r[0][1];
            win_r[1]    <= arr_r[0][2];
            win_r[2]    <= tap2_s;
            win_r[3]    <= arr_r[1][1];
            win_r[4]    <= arr_r[1][2];
            win_r[5]    <= tap1_s;
            win_r[6]    <= arr_r[2][1];
            win_r[7]    <= arr_r[2][2];
            win_r[8]    <= pix_in;
            win_valid_r <= 1'b1;
            win_last_r  <= last_s;
        end else if (win_accept_s) begin
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else begin
            win_valid_r <= win_valid_r;
            win_last_r  <= win_last_r;
        end
    end

`ifdef CONV3X3_WIN_COORD_EN
    // Top-left coordinate captured alongside the window words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_r <= {RW{1'b0}};
            win_col_r <= {CW{1'b0}};
        end else if (load_s) begin
            win_row_r <= pos_row_s - RW'(2);
            win_col_r <= pos_col_s - CW'(2);
        end else begin
            win_row_r <= win_row_r;
            win_col_r <= win_col_r;
        end
    end

    assign win_row = win_row_r;
    assign win_col = win_col_r;
`endif

    assign win0      = win_r[0];
    assign win1      = win_r[1];
    assign win2      = win_r[2];
    assign win3      = win_r[3];
    assign win4      = win_r[4];
    assign win5      = win_r[5];
    assign win6      = win_r[6];
    assign win7      = win_r[7];
    assign win8      = win_r[8];
    assign win_valid = win_valid_r;
    assign win_last  = win_last_r;

endmodule

// File: tb/tb_conv3x3_window.sv
// -----------------------------------------------------------------------------
// tb_conv3x3_window
//
// Self-checking bench for conv3x3_window on a 5x5 image. A reference model
// stores each accepted pixel into a full-frame array and, whenever a pixel
// completes a neighbourhood, queues the expected window read straight from
// that array. The DUT output register must equal the queue head whenever the
// queue is non-empty, and win_valid must be low when it is empty.
// -----------------------------------------------------------------------------
module tb_conv3x3_window;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int BD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BD-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          win_ready = 1'b0;
    logic          pix_ready;
    logic          win_valid;
    logic          win_last;
    logic [BD-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
`ifdef CONV3X3_WIN_COORD_EN
    logic [2:0]    win_row;
    logic [2:0]    win_col;
`endif
    logic [8:0][BD-1:0] dut_w;

    assign dut_w = {win8, win7, win6, win5, win4, win3, win2, win1, win0};

    conv3x3_window #(.bit_depth(BD), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .win5      (win5),
        .win6      (win6),
        .win7      (win7),
        .win8      (win8),
        .win_valid (win_valid),
        .win_last  (win_last),
`ifdef CONV3X3_WIN_COORD_EN
        .win_row   (win_row),
        .win_col   (win_col),
`endif
        .win_ready (win_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               last;
        logic [2:0]         row;
        logic [2:0]         col;
        logic [8:0][BD-1:0] w;
    } win_t;

    win_t          exp_q[$];
    logic [BD-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    int            cyc = 0;
    int            nwin = 0;
    int            nlast = 0;
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: place pixel in the frame, queue any completed window
    task automatic model_accept(input logic [BD-1:0] px, input logic sof);
        win_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
            e.last = (mr == H - 1 && mc == W - 1);
            e.row  = 3'(mr - 2);
            e.col  = 3'(mc - 2);
            for (int k = 0; k < 9; k++) e.w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic check_outputs();
        check_value("win_valid", 32'(win_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            for (int k = 0; k < 9; k++)
                check_value($sformatf("win%0d", k), 32'(dut_w[k]), 32'(exp_q[0].w[k]));
            check_value("win_last", 32'(win_last), 32'(exp_q[0].last));
`ifdef CONV3X3_WIN_COORD_EN
            check_value("win_row", 32'(win_row), 32'(exp_q[0].row));
            check_value("win_col", 32'(win_col), 32'(exp_q[0].col));
`endif
        end
    endtask

    // One clock: check outputs, drive inputs, predict handshakes
    task automatic run_cycle(input logic pv, input logic [BD-1:0] px, input logic sof,
                             input logic wr, output logic acc);
        logic exp_ready;
        @(negedge clk);
        check_outputs();
        pix_valid = pv;
        pix_in    = px;
        pix_sof   = sof;
        win_ready = wr;
        #1;
        exp_ready = (exp_q.size() == 0) || wr;
        check_value("pix_ready", 32'(pix_ready), 32'(exp_ready));
        if (wr && exp_q.size() != 0) begin
            if (exp_q[0].last) nlast++;
            nwin++;
            void'(exp_q.pop_front());
        end
        acc = pv && exp_ready;
        if (acc) model_accept(px, sof);
        cyc++;
    endtask

    function automatic logic pick_wr(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            2:       return 1'($urandom_range(1));
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_pixel(input logic [BD-1:0] px, input logic sof, input int mode);
        logic acc;
        logic pv;
        bit   done;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            pv = (mode == 2) ? ($urandom_range(3) != 0) : 1'b1;
            if (pv) run_cycle(1'b1, px, sof, pick_wr(mode), acc);
            else    run_cycle(1'b0, BD'($urandom), 1'($urandom_range(1)), pick_wr(mode), acc);
            if (acc) done = 1;
        end
        if (!done) check_value("pixel_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int base, input logic sof, input int mode, input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pixel(rnd ? BD'($urandom) : BD'(base + 5 * r + c), sof && r == 0 && c == 0, mode);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) run_cycle(1'b0, '0, 1'b0, 1'b1, acc);
        if (exp_q.size() != 0) check_value("drain_timeout", 32'd0, 32'd1);
        run_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        win_ready = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_value("rst_win_valid", 32'(win_valid), 32'd0);
        check_value("rst_win_last", 32'(win_last), 32'd0);
        check_value("rst_pix_ready", 32'(pix_ready), 32'd1);
        for (int k = 0; k < 9; k++) check_value($sformatf("rst_win%0d", k), 32'(dut_w[k]), 32'd0);
`ifdef CONV3X3_WIN_COORD_EN
        check_value("rst_win_row", 32'(win_row), 32'd0);
        check_value("rst_win_col", 32'(win_col), 32'd0);
`endif
        exp_q.delete();
        mr = 0;
        mc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_counts(input string tag, input int wins, input int lasts);
        check_value({tag, "_windows"}, 32'(nwin), 32'(wins));
        check_value({tag, "_last"}, 32'(nlast), 32'(lasts));
        nwin  = 0;
        nlast = 0;
    endtask

    initial begin
        logic acc;
        do_reset();
        nwin = 0;
        nlast = 0;

        // Plain frame, downstream always ready
        send_frame(0, 1'b1, 0, 1'b0);
        drain();
        check_counts("frame", 9, 1);

        // Same frame with win_ready toggling
        send_frame(0, 1'b1, 1, 1'b0);
        drain();
        check_counts("toggle", 9, 1);

        // Two frames back to back, counters wrap into the second
        send_frame(0, 1'b1, 0, 1'b0);
        send_frame(25, 1'b0, 0, 1'b0);
        drain();
        check_counts("b2b", 18, 2);

        // sof reasserted at frame position (3,1)
        for (int i = 0; i < 16; i++) send_pixel(BD'(100 + i), i == 0, 0);
        send_frame(200, 1'b1, 0, 1'b0);
        drain();
        check_counts("sof_restart", 12, 1);

        // Random pixels, gaps and backpressure
        for (int f = 0; f < 3; f++) send_frame(0, f == 0, 2, 1'b1);
        drain();
        check_counts("random", 27, 3);

        // Reset while a window is stalled, then a frame without sof
        for (int i = 0; i < 13; i++) send_pixel(BD'(300 + i), i == 0, 0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 16'd999, 1'b0, 1'b0, acc);
        do_reset();
        nwin = 0;
        nlast = 0;
        send_frame(400, 1'b0, 0, 1'b0);
        drain();
        check_counts("after_reset", 9, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv3x3_window.md
# conv3x3_window

Streaming 3x3 window generator that feeds the convolution datapath. Accepts one raster-order pixel per cycle over a valid/ready handshake, buffers two image lines internally, and presents each complete 3x3 neighbourhood as nine parallel words on `win0`..`win8`, ready to drive the `in0`..`in8` operands of the 3x3 MAC. Only "valid" windows are emitted (no padding): (IMG_W-2)*(IMG_H-2) windows per frame.

## Interface
- `bit_depth`, 16, pixel word width.
- `IMG_W`, 28, image width in pixels (>= 3).
- `IMG_H`, 28, image height in pixels (>= 3).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `pix_in`  in  bit_depth  input pixel, raster order.
- `pix_valid`  in  1  `pix_in` valid.
- `pix_sof`  in  1  qualifies the accepted pixel as frame position (0,0).
- `pix_ready`  out  1  block can accept a pixel this cycle.
- `win0`..`win8`  out  bit_depth each  window, row-major; `win0` = top-left, `win8` = bottom-right.
- `win_valid`  out  1  window outputs valid.
- `win_last`  out  1  qualifies the final window of a frame.
- `win_ready`  in  1  downstream accepts window.

## Operation
- Pixel accept: `pix_valid & pix_ready`. Window accept: `win_valid & win_ready`.
- `pix_ready = ~win_valid | win_ready` (single output register; combinational from `win_valid`/`win_ready`).
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1), width `$clog2` of the range, advance only on pixel accept. `col` wraps to 0 and increments `row`; after (IMG_H-1, IMG_W-1) both wrap to 0.
- `pix_sof` on an accepted pixel forces that pixel to position (0,0); counters continue from (0,1). `pix_sof` without accept is ignored.
- Two line buffers of IMG_W words (shift register or RAM) hold rows r-1 and r-2; a 3x3 register array shifts one column left per accept. Line buffers are not reset; stale content is never emitted because of the row/col gating below.
- On accept of pixel (r,c) with r >= 2 and c >= 2: output register loads window rows r-2..r, columns c-2..c; `win_valid` <= 1; `win_last` <= (r == IMG_H-1 && c == IMG_W-1).
- Accept at c < 2 or r < 2 with simultaneous window accept: `win_valid` <= 0.
- Window accept without new window load: `win_valid` <= 0. Outputs hold stable while `win_valid & ~win_ready`.

## Timing
- Reset (async assert, sync release): `col`=0, `row`=0, `win_valid`=0, `win_last`=0, `win0`..`win8`=0, 3x3 array=0; `pix_ready`=1 after reset.
- Latency: window appears the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel and one window per cycle with `win_ready` held high; no bubbles at line or frame wrap beyond the inherent column/row gating.
- Reset mid-frame: all state above cleared immediately; next accepted pixel is (0,0) regardless of `pix_sof`.
- Simultaneous window accept and new window load: new window replaces old in the same edge, `win_valid` stays 1.

## Configuration
- `CONV3X3_WIN_COORD_EN`: when defined, adds outputs `win_row` [$clog2(IMG_H)-1:0] and `win_col` [$clog2(IMG_W)-1:0], registered with the window, giving its top-left coordinate (r-2, c-2); reset 0. When undefined, ports and logic are absent; all other behaviour identical.

## Test plan
- IMG_W=IMG_H=5, pixel = 5r+c, `pix_sof` on first, `win_ready`=1 -> first `win_valid` one cycle after pixel 12 accept with win0..win8 = 0,1,2,5,6,7,10,11,12; 9 windows total, last = 12,13,14,17,18,19,22,23,24 with `win_last`=1.
- Same stream, `win_ready` toggling 1-0 -> `pix_ready` drops while window held; outputs stable during stall; same 9 windows in order, none lost or duplicated.
- Two back-to-back frames without gaps -> 18 windows; second frame's first window = first frame's values + 25 offset pattern (pixel = 25+5r+c), `win_last` exactly twice.
- `pix_sof` reasserted at frame position (3,1) -> counters restart; next 25 pixels produce 9 windows matching a fresh frame.
- `rst_n` asserted mid-window-stall -> `win_valid`, `win_last`, `win0`..`win8` go 0 immediately; restart frame yields correct first window.
- With `CONV3X3_WIN_COORD_EN`, 5x5 frame -> (`win_row`,`win_col`) sequence (0,0),(0,1),(0,2),(1,0)…(2,2).
